inst_queue: RTL

- Parametrised fetch-to-decode instruction queue. It is the successor to the single-register fetch/decode transfer stage.
- Buffers up to DEPTH fetched instructions with their PCs and holds them while decode stalls.
- Issues fetch credits so that the queue can never overflow.
- On a flush, kills all queued entries and silently discards every in-flight fetch response issued before the flush. This replaces the old flush_done and branch-squash handling.

---
 rtl/inst_queue_pkg.sv | 17 +
 rtl/inst_queue_ram.sv | 25 ++
 rtl/inst_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared defaults and response classification for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int IQ_INST_W  = 32;
  localparam int IQ_PC_W    = 32;
  localparam int IQ_DEPTH   = 4;
  localparam int IQ_MAX_OUT = 4;

  typedef enum logic [2:0] {
    RESP_NONE,
    RESP_PUSH,
    RESP_STALE,
    RESP_FLUSHED,
    RESP_OVF
  } resp_kind_e;

endpackage

// File: rtl/inst_queue_ram.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
module inst_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Data storage is deliberately not reset; validity is tracked by the queue count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with credit-based fetch flow control and
// flush-time discarding of stale in-flight fetch responses.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int INST_W  = IQ_INST_W,
  parameter int PC_W    = IQ_PC_W,
  parameter int DEPTH   = IQ_DEPTH,
  parameter int MAX_OUT = IQ_MAX_OUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       req_fire,
  output logic                       fetch_req_ok,
  input  logic                       resp_valid,
  input  logic [INST_W-1:0]          resp_inst,
  input  logic [PC_W-1:0]            resp_pc,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [INST_W-1:0]          dec_inst,
  output logic [PC_W-1:0]            dec_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int SUM_W = CNT_W + OUT_W + 1;
  localparam int ENT_W = INST_W + PC_W;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] discard;

  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  resp_kind_e       resp_kind;
  logic [OUT_W-1:0] outstanding_next;
  logic [SUM_W-1:0] live_inflight;
  logic [SUM_W-1:0] committed;
  logic [ENT_W-1:0] head_entry;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop in the flush cycle is ignored: the head is discarded by decode itself.
  assign pop = !empty && dec_ready && !flush;

  always_comb begin
    resp_kind = RESP_NONE;
    if (resp_valid) begin
      if (flush) begin
        resp_kind = RESP_FLUSHED;
      end else if (discard != '0) begin
        resp_kind = RESP_STALE;
      end else if (full && !pop) begin
        resp_kind = RESP_OVF;
      end else begin
        resp_kind = RESP_PUSH;
      end
    end
  end

  assign push = (resp_kind == RESP_PUSH);

  assign outstanding_next = outstanding + OUT_W'(req_fire) - OUT_W'(resp_valid);

  // Stale responses still in flight never reach the queue, so they need no credit.
  assign live_inflight = SUM_W'(outstanding) - SUM_W'(discard);
  assign committed     = SUM_W'(count) + live_inflight;
  assign fetch_req_ok  = (committed < SUM_W'(DEPTH)) && (outstanding < OUT_W'(MAX_OUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      ovf_err     <= 1'b0;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding_next;
      discard     <= outstanding_next;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding_next;
      if (resp_kind == RESP_STALE) begin
        discard <= discard - OUT_W'(1);
      end
      if (resp_kind == RESP_OVF) begin
        ovf_err <= 1'b1;
      end
    end
  end

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({resp_inst, resp_pc}),
    .rd_addr (rd_ptr),
    .rd_data (head_entry)
  );

  assign dec_valid = !empty;
  assign dec_inst  = dec_valid ? head_entry[ENT_W-1:PC_W] : '0;
  assign dec_pc    = dec_valid ? head_entry[PC_W-1:0] : '0;
  assign occupancy = count;

endmodule
